// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for the multi-cycle ALU.
// The master side presents operations and consumes results; the slave side is the ALU.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             neg;
  logic             dz;
  logic             illegal;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, carry, ovf, neg, dz, illegal
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, carry, ovf, neg, dz, illegal
  );
endinterface

// File: rtl/alu_mc.sv
// Parametrised multi-cycle ALU: single-cycle logic/arith/shift/compare ops,
// iterative shift-add multiply and restoring divide, valid/ready on both sides.
// At most one operation is in flight; results are held until the consumer takes them.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  // Final iteration index; the counter never goes past it.
  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [SHW:0]       cnt;
  logic [WIDTH-1:0]   a_reg;       // multiplicand
  logic [2*WIDTH-1:0] acc_reg;     // {partial product high, multiplier / product low}
  logic [WIDTH-1:0]   b_reg;       // divisor
  logic [WIDTH-1:0]   quo_reg;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   rem_reg;     // partial remainder
  logic               is_rem_reg;  // REMU rather than DIVU
  logic [WIDTH-1:0]   result_reg;
  logic               zero_reg, carry_reg, ovf_reg, neg_reg, dz_reg, illegal_reg;
  logic               out_valid_reg;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf, alu_dz, alu_ill;
  logic [WIDTH:0]     sum_ext, diff_ext;
  logic [SHW-1:0]     shamt;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_next, quo_next, div_res;

  // Single-cycle datapath; also covers the divide-by-zero shortcut.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_dz    = 1'b0;
    alu_ill   = 1'b0;
    shamt     = bus.b[SHW-1:0];
    sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
    diff_ext  = {1'b0, bus.a} - {1'b0, bus.b};
    case (bus.op)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $signed(bus.a) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_MUL:  alu_res = '0;
      OP_DIVU: begin
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      OP_REMU: begin
        alu_res = bus.a;
        alu_dz  = 1'b1;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
    mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {rem_reg, quo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    div_ok    = ~div_diff[WIDTH];
    rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {quo_reg[WIDTH-2:0], div_ok};
    div_res   = is_rem_reg ? rem_next : quo_next;
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      a_reg         <= '0;
      acc_reg       <= '0;
      b_reg         <= '0;
      quo_reg       <= '0;
      rem_reg       <= '0;
      is_rem_reg    <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      carry_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      neg_reg       <= 1'b0;
      dz_reg        <= 1'b0;
      illegal_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cnt <= '0;
            if (bus.op == OP_MUL) begin
              a_reg   <= bus.a;
              acc_reg <= {{WIDTH{1'b0}}, bus.b};
              state   <= MUL;
            end else if ((bus.op == OP_DIVU || bus.op == OP_REMU) && bus.b != '0) begin
              b_reg      <= bus.b;
              quo_reg    <= bus.a;
              rem_reg    <= '0;
              is_rem_reg <= (bus.op == OP_REMU);
              state      <= DIV;
            end else begin
              result_reg    <= alu_res;
              zero_reg      <= (alu_res == '0);
              neg_reg       <= alu_res[WIDTH-1];
              carry_reg     <= alu_carry;
              ovf_reg       <= alu_ovf;
              dz_reg        <= alu_dz;
              illegal_reg   <= alu_ill;
              out_valid_reg <= 1'b1;
              state         <= DONE;
            end
          end
        end
        MUL: begin
          acc_reg <= mul_next;
          if (cnt == LAST) begin
            result_reg    <= mul_next[WIDTH-1:0];
            zero_reg      <= (mul_next[WIDTH-1:0] == '0);
            neg_reg       <= mul_next[WIDTH-1];
            carry_reg     <= 1'b0;
            ovf_reg       <= |mul_next[2*WIDTH-1:WIDTH];
            dz_reg        <= 1'b0;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          if (cnt == LAST) begin
            result_reg    <= div_res;
            zero_reg      <= (div_res == '0);
            neg_reg       <= div_res[WIDTH-1];
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            dz_reg        <= 1'b0;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n so every output reads 0 while reset is held.
  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.carry     = carry_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.neg       = neg_reg;
  assign bus.dz        = dz_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the RISC datapath.
- Generalises the 16-bit single-cycle ALU in three ways: width is a parameter, the op set is wider (shifts, signed compare, multiply, divide), and it reports full flags.
- Multiply and divide are iterative, one bit per cycle.
- Operands enter and results leave through valid/ready handshakes, so the pipeline can stall on long ops.

Parameters:
- WIDTH, 16, operand/result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  operation select
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- zero  out  1  result == 0
- carry  out  1  ADD carry-out / SUB borrow
- ovf  out  1  signed overflow (ADD/SUB), or upper product nonzero (MUL)
- neg  out  1  result[WIDTH-1]
- dz  out  1  divide by zero (DIVU/REMU)
- illegal  out  1  op code unsupported

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE.
  - All outputs 0, except in_ready=1 once rst_n is high.
  - Reset asserted mid-operation aborts it; no result is ever delivered for the aborted op.
- Ops:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL: a<<b[SHW-1:0].
  - 6 SRL: logical right shift.
  - 7 SRA: arithmetic right shift.
  - 8 SLT: signed a<b gives 1, else 0.
  - 9 MUL: low WIDTH bits of unsigned a*b.
  - 10 DIVU: unsigned quotient.
  - 11 REMU: unsigned remainder.
  - 12-15: result=0, illegal=1.
- Flags:
  - zero and neg are computed from the final result for every op.
  - carry is 0 except for ADD/SUB.
  - ovf is 0 except for ADD/SUB/MUL.
  - dz is 0 except for DIVU/REMU with b==0.
- FSM states: IDLE, MUL, DIV, DONE.
  - in_ready = (state==IDLE). Accept occurs when in_valid && in_ready.
  - IDLE, accept of a single-cycle op (ops 0-8, 12-15): compute, register result and flags, go to DONE. Latency 1 (out_valid on the cycle after accept).
  - IDLE, accept of MUL: latch operands, go to MUL.
    - Shift-add runs for WIDTH cycles using a 2*WIDTH-bit accumulator, then DONE.
    - Latency WIDTH+1.
  - IDLE, accept of DIVU/REMU with b!=0: go to DIV.
    - Restoring division, WIDTH cycles, then DONE.
    - Latency WIDTH+1.
  - IDLE, accept of DIVU/REMU with b==0: skip iteration and go straight to DONE, latency 1, dz=1.
    - DIVU result = all ones.
    - REMU result = a.
  - DONE: out_valid=1. result and flags are held stable until out_ready.
    - When out_ready=1, go to IDLE the next cycle; out_valid drops and in_ready rises.
    - No new operation is accepted in DONE, so at most one op is in flight. Max throughput is one op per 2 cycles.
  - An iteration counter is SHW+1 bits wide and counts 0..WIDTH-1. No wrap beyond WIDTH.
- Operands are captured at accept. a, b and op may change freely afterwards.
- in_valid without in_ready (busy): ignored. The upstream holds the op until accepted.
- All arithmetic is modulo 2^WIDTH.
  - Shift amounts use only the low SHW bits of b.
  - SRA by 0 returns a unchanged.

Test Plan (WIDTH=16):
- ADD a=0x7FFF b=0x0001 → result 0x8000, ovf=1, neg=1, carry=0, zero=0. out_valid exactly 1 cycle after accept.
- SUB a=0x0003 b=0x0005 → 0xFFFE, carry=1, neg=1. Then ADD 0xFFFF+0x0001 → 0x0000, zero=1, carry=1, ovf=0.
- MUL a=0x0100 b=0x0101 → result 0x0100, ovf=1. in_ready=0 for cycles 1-16; out_valid at cycle 17 after accept.
- DIVU 100/7 → 14, REMU 100/7 → 2 (latency 17 each). DIVU 0x1234/0 → 0xFFFF, dz=1, latency 1. REMU 0x1234/0 → 0x1234, dz=1.
- Backpressure: complete SRA 0x8000>>3 (expect 0xF000), hold out_ready=0 for 3 cycles → out_valid stays 1, result stable, in_ready=0, new in_valid ignored. Raise out_ready → in_ready=1 next cycle.
- Assert rst_n=0 during MUL iteration 5 → all outputs 0 immediately. After release in_ready=1, out_valid stays 0, and a fresh op 14 → result 0, illegal=1.
